// File: rtl/vend_actuator_sequencer.sv
// Actuator sequencer behind the vending FSM: captures request edges, fires one
// actuator at a time for a fixed on-time plus idle gap, and tracks stock levels.
module vend_actuator_sequencer #(
  parameter int unsigned PULSE_CYCLES = 100,
  parameter int unsigned GAP_CYCLES   = 50,
  parameter logic [7:0]  MASK_INIT    = 8'd50,
  parameter logic [7:0]  COIN1_INIT   = 8'd50,
  parameter logic [7:0]  COIN2_INIT   = 8'd50
) (
  input  logic clk,
  input  logic reset,
  input  logic dispense,
  input  logic one_balance,
  input  logic two_balance,
  input  logic refill,
  output logic mask_motor,
  output logic coin1_drive,
  output logic coin2_drive,
  output logic busy,
  output logic mask_empty,
  output logic coin1_empty,
  output logic coin2_empty,
  output logic fault,
  output logic overrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, GAP = 2'd2} state_t;

  localparam logic [15:0] PULSE_LD = PULSE_CYCLES[15:0];
  localparam logic [15:0] GAP_LD   = GAP_CYCLES[15:0];

  state_t      state;
  logic [15:0] timer;
  logic [2:0]  pending;
  logic [2:0]  prev;
  logic [2:0]  drive_sel;
  logic [7:0]  mask_stock;
  logic [7:0]  coin1_stock;
  logic [7:0]  coin2_stock;
  logic [2:0]  req;
  logic [2:0]  edges;
  logic [2:0]  pick;
  logic        pick_empty;

  // Channel bit order everywhere: [0] mask, [1] coin1, [2] coin2.
  always_comb begin
    req        = {two_balance, one_balance, dispense};
    edges      = req & ~prev;
    pick       = 3'b000;
    pick_empty = 1'b0;
    if (state == IDLE) begin
      if (pending[0]) begin
        pick       = 3'b001;
        pick_empty = mask_empty;
      end else if (pending[1]) begin
        pick       = 3'b010;
        pick_empty = coin1_empty;
      end else if (pending[2]) begin
        pick       = 3'b100;
        pick_empty = coin2_empty;
      end
    end
  end

  assign mask_empty  = (mask_stock == 8'd0);
  assign coin1_empty = (coin1_stock == 8'd0);
  assign coin2_empty = (coin2_stock == 8'd0);
  assign busy        = (|pending) || (state != IDLE);
  assign {coin2_drive, coin1_drive, mask_motor} = drive_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= 16'd0;
      pending     <= 3'b000;
      prev        <= 3'b000;
      drive_sel   <= 3'b000;
      mask_stock  <= MASK_INIT;
      coin1_stock <= COIN1_INIT;
      coin2_stock <= COIN2_INIT;
      fault       <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      prev    <= req;
      // A same-channel edge in the clearing cycle survives as a fresh request.
      pending <= (pending & ~pick) | edges;

      if (refill) begin
        mask_stock  <= MASK_INIT;
        coin1_stock <= COIN1_INIT;
        coin2_stock <= COIN2_INIT;
        fault       <= 1'b0;
        overrun     <= 1'b0;
      end else begin
        if (|(edges & pending & ~pick)) overrun <= 1'b1;
        if ((|pick) && pick_empty) fault <= 1'b1;
        if ((|pick) && !pick_empty) begin
          if (pick[0]) mask_stock  <= mask_stock - 8'd1;
          if (pick[1]) coin1_stock <= coin1_stock - 8'd1;
          if (pick[2]) coin2_stock <= coin2_stock - 8'd1;
        end
      end

      case (state)
        IDLE: begin
          if ((|pick) && !pick_empty) begin
            state     <= ON;
            timer     <= PULSE_LD;
            drive_sel <= pick;
          end
        end
        ON: begin
          if (timer <= 16'd1) begin
            state     <= GAP;
            timer     <= GAP_LD;
            drive_sel <= 3'b000;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        GAP: begin
          if (timer <= 16'd1) begin
            state <= IDLE;
            timer <= 16'd0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          timer     <= 16'd0;
          drive_sel <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_actuator_sequencer.sv
// Randomized scoreboard bench for vend_actuator_sequencer; a time-based service
// model predicts each pulse and the status flags cycle by cycle.
module tb_vend_actuator_sequencer;

  localparam int P   = 4;
  localparam int G   = 2;
  localparam int MI  = 3;
  localparam int C1I = 2;
  localparam int C2I = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dispense = 1'b0, one_balance = 1'b0, two_balance = 1'b0, refill = 1'b0;
  logic mask_motor, coin1_drive, coin2_drive, busy;
  logic mask_empty, coin1_empty, coin2_empty, fault, overrun;

  vend_actuator_sequencer #(
    .PULSE_CYCLES(P), .GAP_CYCLES(G),
    .MASK_INIT(8'(MI)), .COIN1_INIT(8'(C1I)), .COIN2_INIT(8'(C2I))
  ) dut (
    .clk(clk), .reset(reset), .dispense(dispense), .one_balance(one_balance),
    .two_balance(two_balance), .refill(refill), .mask_motor(mask_motor),
    .coin1_drive(coin1_drive), .coin2_drive(coin2_drive), .busy(busy),
    .mask_empty(mask_empty), .coin1_empty(coin1_empty), .coin2_empty(coin2_empty),
    .fault(fault), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int ch;
    int start;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   m_stock[3];
  bit   m_pending[3];
  bit   m_prev[3];
  bit   m_fault, m_overrun, exp_busy;
  int   idle_from;
  int   cleared;
  logic [2:0] lvl;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, actual, expected);
    end
  endtask

  // Reference model: each request is a service slot of P+G+1 cycles starting
  // when the sequencer is free; time is tracked as plain cycle arithmetic.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_stock[0] = MI; m_stock[1] = C1I; m_stock[2] = C2I;
      for (int i = 0; i < 3; i++) begin
        m_pending[i] = 1'b0;
        m_prev[i]    = 1'b0;
      end
      m_fault = 1'b0; m_overrun = 1'b0; exp_busy = 1'b0;
      idle_from = 0;
      exp_q.delete();
    end else begin
      cleared = -1;
      if (cyc >= idle_from)
        for (int i = 0; i < 3; i++)
          if (m_pending[i] && cleared < 0) cleared = i;
      if (cleared >= 0) begin
        m_pending[cleared] = 1'b0;
        if (m_stock[cleared] > 0) begin
          m_stock[cleared]--;
          exp_q.push_back('{ch: cleared, start: cyc});
          idle_from = cyc + P + G + 1;
        end else begin
          m_fault = 1'b1;
        end
      end
      lvl = {two_balance, one_balance, dispense};
      for (int i = 0; i < 3; i++) begin
        if (lvl[i] && !m_prev[i]) begin
          if (m_pending[i] && cleared != i) m_overrun = 1'b1;
          m_pending[i] = 1'b1;
        end
        m_prev[i] = lvl[i];
      end
      if (refill) begin
        m_stock[0] = MI; m_stock[1] = C1I; m_stock[2] = C2I;
        m_fault = 1'b0; m_overrun = 1'b0;
      end
      exp_busy = m_pending[0] || m_pending[1] || m_pending[2] || (cyc < idle_from - 1);
    end
  end

  // Monitor: flags every cycle, and each completed pulse against the queue.
  bit         in_pulse = 1'b0;
  logic [2:0] cur_drv;
  int         p_start, p_len;
  exp_t       e;
  logic [2:0] drv;

  always @(negedge clk) begin
    if (reset) begin
      in_pulse = 1'b0;
    end else begin
      drv = {coin2_drive, coin1_drive, mask_motor};
      check_output("busy", int'(busy), int'(exp_busy));
      check_output("fault", int'(fault), int'(m_fault));
      check_output("overrun", int'(overrun), int'(m_overrun));
      check_output("mask_empty", int'(mask_empty), int'(m_stock[0] == 0));
      check_output("coin1_empty", int'(coin1_empty), int'(m_stock[1] == 0));
      check_output("coin2_empty", int'(coin2_empty), int'(m_stock[2] == 0));
      check_output("drive_onehot", int'($countones(drv) <= 1), 1);
      if (!in_pulse && drv != 3'b000) begin
        in_pulse = 1'b1; cur_drv = drv; p_start = cyc; p_len = 1;
      end else if (in_pulse && drv == cur_drv) begin
        p_len++;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        if (exp_q.size() == 0) begin
          check_output("unexpected_pulse", int'(cur_drv), 0);
        end else begin
          e = exp_q.pop_front();
          check_output("pulse_channel", int'(cur_drv), 1 << e.ch);
          check_output("pulse_start", p_start, e.start);
          check_output("pulse_length", p_len, P);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic d, input logic o, input logic t, input logic r);
    @(negedge clk);
    #1;
    dispense = d; one_balance = o; two_balance = t; refill = r;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    idle_cycles(3);

    // single mask request
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(12);
    // all three channels at once; coin2 stock is zero
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    idle_cycles(28);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(2);
    // second dispense edge three cycles after the first
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(20);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(2);
    // two dispense edges while a coin1 pulse is in progress
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles(2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(25);

    // reset in the middle of a mask pulse, request held high through release
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50 && !mask_motor; i++) @(negedge clk);
    check_output("mask_pulse_seen", int'(mask_motor), 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_output("drive_after_reset", int'({coin2_drive, coin1_drive, mask_motor}), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    idle_cycles(15);

    for (int i = 0; i < 3000; i++)
      apply_stimulus(($urandom_range(0, 5) == 0) ? ~dispense : dispense,
                     ($urandom_range(0, 5) == 0) ? ~one_balance : one_balance,
                     ($urandom_range(0, 7) == 0) ? ~two_balance : two_balance,
                     ($urandom_range(0, 59) == 0));

    idle_cycles(60);
    check_output("queue_drained", exp_q.size(), 0);
    check_output("no_pulse_open", int'(in_pulse), 0);
    check_output("busy_at_end", int'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_actuator_sequencer.md
# vend_actuator_sequencer

Sequences the physical actuators behind the vending machine controller: mask motor, ₹1 coin hopper and ₹2 coin hopper. It captures the controller's `dispense`, `one_balance` and `two_balance` outputs as one-deep per-channel requests. It then fires each actuator for a fixed on-time, one at a time, with an inter-pulse gap, and tracks remaining stock of masks and coins. It sits between the vending FSM and the actuator driver pins.

## Interface
- `PULSE_CYCLES`, default 100: actuator on-time in clk cycles (1..65535).
- `GAP_CYCLES`, default 50: idle gap after each pulse (1..65535).
- `MASK_INIT`, default 8'd50: mask stock loaded on reset/refill.
- `COIN1_INIT`, default 8'd50: ₹1 coin stock loaded on reset/refill.
- `COIN2_INIT`, default 8'd50: ₹2 coin stock loaded on reset/refill.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `dispense`  in  1  mask request level from the vending FSM.
- `one_balance`  in  1  ₹1 change request level.
- `two_balance`  in  1  ₹2 change request level.
- `refill`  in  1  one-cycle pulse; reload all stock counters, clear `fault`/`overrun`.
- `mask_motor`  out  1  mask actuator drive (registered).
- `coin1_drive`  out  1  ₹1 hopper drive (registered).
- `coin2_drive`  out  1  ₹2 hopper drive (registered).
- `busy`  out  1  any request pending or state ≠ IDLE.
- `mask_empty` / `coin1_empty` / `coin2_empty`  out  1 each  corresponding stock counter == 0.
- `fault`  out  1  sticky; a request was dropped because its stock was 0.
- `overrun`  out  1  sticky; a request arrived while that channel was already pending.

## Operation
- Request capture:
  - Each request input has a previous-value register (reset 0).
  - A rising edge (input 1 at a posedge, previous 0) sets that channel's pending bit.
- FSM states: IDLE, ON, GAP. A registered channel select records which actuator ON drives.
- IDLE, selecting by priority mask > coin1 > coin2:
  - If the selected channel's stock is > 0: clear its pending bit, decrement its stock, load the timer with PULSE_CYCLES, and go to ON.
  - If the selected stock is 0: clear its pending bit, set `fault`, and stay in IDLE. That cycle is consumed.
  - If nothing is pending, stay in IDLE.
- ON: drive the selected actuator for exactly PULSE_CYCLES cycles, then load GAP_CYCLES and go to GAP.
- GAP: all drives low for GAP_CYCLES cycles, then return to IDLE.
- Timer is 16-bit and counts down.
- Stock counters are 8-bit and never go below 0.
- Same-channel collision:
  - A new edge in the same cycle that pending is cleared by IDLE→ON leaves pending set; the new request is kept.
  - A new edge while pending is already set and not being cleared sets `overrun`. The request merges and counts once.
- `refill` loads all counters from the INIT parameters and clears `fault`/`overrun`.
  - Refill overrides a same-cycle decrement.
  - An in-progress pulse is not affected.
- Reset values:
  - State IDLE, timer 0.
  - All pending bits and previous-value registers 0.
  - All drives 0; `busy`, `fault`, `overrun` 0.
  - Stock counters at their INIT values; empty flags therefore follow INIT == 0.
- Reset mid-pulse drops the drive and all pending requests immediately (asynchronous).
- A request input held high through reset release is seen as an edge at the first posedge after release.

## Timing
- Edge detected at posedge k → pending bit set at k.
- Drive rises after posedge k+1 and stays high for PULSE_CYCLES cycles, falling after posedge k+1+PULSE_CYCLES.
- IDLE is re-entered after posedge k+1+PULSE_CYCLES+GAP_CYCLES.
- Service period per request is PULSE_CYCLES+GAP_CYCLES+1 cycles. The next actuator rises one cycle after IDLE is re-entered.
- At most one drive is high in any cycle.
- `busy` rises in the same cycle the pending bit sets. It falls on the posedge where IDLE is entered with no pending requests.
- Empty flags are combinational from the stock registers and change the cycle after a decrement or refill.

## Test plan
With PULSE_CYCLES=4, GAP_CYCLES=2 and edges at posedge k:
- Single `dispense` edge at k:
  - `mask_motor` high for posedges k+1..k+4, low after k+5.
  - `busy` low after k+7.
  - Mask stock 50→49.
- `dispense`, `one_balance`, `two_balance` all rising at k:
  - `mask_motor` rises after k+1, `coin1_drive` after k+8, `coin2_drive` after k+15.
  - `busy` low after k+22.
  - Stocks 49/49/49; drives never overlap.
- COIN2_INIT=0, `two_balance` edge:
  - No `coin2_drive` pulse.
  - `fault`=1 after k+1; `coin2_empty`=1 from reset.
  - `busy` low after k+1.
- Two `dispense` edges 3 cycles apart (second edge during ON with pending already cleared):
  - Two mask pulses, 7 cycles apart.
  - `overrun`=0.
- Two `dispense` edges in IDLE while blocked behind a coin1 pulse: `overrun`=1 and only one mask pulse.
- Reset asserted mid-pulse with stock 49, then `refill`:
  - Drive low immediately on reset; stock back to 50.
  - After a fault, `refill` clears `fault` and `mask_empty`.
